// File: rtl/logic4_deser.sv
// Serial 2-bit-symbol to 4-state word deserializer with SOF framing and a valid/ready output hold.
// Optional frame parity symbol is enabled by defining LOGIC4_DESER_PARITY_EN.
module logic4_deser #(
  parameter int WORD_SYMS = 8
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic                 in_sof,
  input  logic [1:0]           in_sym,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [WORD_SYMS-1:0] out_data,
  output logic                 out_err,
  output logic [7:0]           drop_cnt
);

  localparam int IW = $clog2(WORD_SYMS + 1);
`ifdef LOGIC4_DESER_PARITY_EN
  localparam int FLEN = WORD_SYMS + 1;
`else
  localparam int FLEN = WORD_SYMS;
`endif

  typedef enum logic [1:0] {IDLE, COLLECT, HOLD} state_t;

  state_t          state, state_d;
  logic [IW-1:0]   idx;
  logic            acc, start, restart, last;

  function automatic logic dec(input logic [1:0] s);
    case (s)
      2'b00:   dec = 1'b0;
      2'b01:   dec = 1'b1;
      2'b10:   dec = 1'bz;
      default: dec = 1'bx;
    endcase
  endfunction

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_d;
  end

  // in_ready is gated by rst_n so it is low throughout reset and high right after release
  always_comb begin
    in_ready = rst_n && ((state != HOLD) || out_ready);
    acc      = in_valid && in_ready;
    state_d  = state;
    start    = 1'b0;
    restart  = 1'b0;
    last     = 1'b0;
    case (state)
      IDLE: if (acc && in_sof) begin
        start   = 1'b1;
        state_d = COLLECT;
      end
      COLLECT: if (acc) begin
        if (in_sof) begin
          start   = 1'b1;
          restart = 1'b1;
        end else if (idx == IW'(FLEN - 1)) begin
          last    = 1'b1;
          state_d = HOLD;
        end
      end
      HOLD: if (out_ready) begin
        state_d = IDLE;
        if (acc && in_sof) begin
          start   = 1'b1;
          state_d = COLLECT;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign out_valid = (state == HOLD);

`ifdef LOGIC4_DESER_PARITY_EN
  logic par_acc;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      idx      <= '0;
      out_data <= '0;
      drop_cnt <= '0;
`ifdef LOGIC4_DESER_PARITY_EN
      par_acc  <= 1'b0;
      out_err  <= 1'b0;
`endif
    end else if (start) begin
      idx <= IW'(1);
      for (int k = 0; k < WORD_SYMS; k++)
        out_data[k] <= (k == 0) ? dec(in_sym) : 1'b0;
      if (restart && (drop_cnt != 8'hff)) drop_cnt <= drop_cnt + 8'd1;
`ifdef LOGIC4_DESER_PARITY_EN
      par_acc <= (in_sym == 2'b01);
`endif
    end else if ((state == COLLECT) && acc) begin
      for (int k = 0; k < WORD_SYMS; k++)
        if (idx == IW'(k)) out_data[k] <= dec(in_sym);
      idx <= last ? '0 : idx + IW'(1);
`ifdef LOGIC4_DESER_PARITY_EN
      // only symbols that decode to 1 contribute; z and x count as 0
      if (last) out_err <= (in_sym != {1'b0, par_acc});
      else      par_acc <= par_acc ^ (in_sym == 2'b01);
`endif
    end
  end

`ifndef LOGIC4_DESER_PARITY_EN
  assign out_err = 1'b0;
`endif

endmodule

// File: doc/logic4_deser.md
LOGIC4_DESER -- requirements
Module: logic4_deser

Interface
REQ-001 The module SHALL have parameter WORD_SYMS, default 8: the number of 4-state symbols per output word (legal range 2..32).
REQ-002 The module SHALL have port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-003 The module SHALL have port rst_n, input, 1 bit: reset, asynchronous and active-low.
REQ-004 The module SHALL have port in_valid, input, 1 bit: a symbol is presented on in_sym.
REQ-005 The module SHALL have port in_ready, output, 1 bit: the block accepts the symbol this cycle.
REQ-006 The module SHALL have port in_sof, input, 1 bit: the presented symbol is the first symbol of a frame.
REQ-007 The module SHALL have port in_sym, input, 2 bits: symbol encoding 00=0, 01=1, 10=z, 11=x.
REQ-008 The module SHALL have port out_valid, output, 1 bit: a word is held on out_data.
REQ-009 The module SHALL have port out_ready, input, 1 bit: the consumer takes the word.
REQ-010 The module SHALL have port out_data, output, WORD_SYMS bits, 4-state logic: the decoded word; the first symbol goes to bit 0.
REQ-011 The module SHALL have port out_err, output, 1 bit: parity error for the held word; constant 0 without the macro.
REQ-012 The module SHALL have port drop_cnt, output, 8 bits: saturating count of abandoned partial frames.

Function
REQ-013 A symbol SHALL be accepted only on a cycle where in_valid and in_ready are both 1.
REQ-014 The FSM SHALL have states IDLE, COLLECT and HOLD; it SHALL leave IDLE only on an accepted symbol with in_sof=1; in IDLE, accepted symbols with in_sof=0 SHALL be discarded without counting.
REQ-015 Each accepted symbol SHALL be decoded and written to out_data bit k, where k is the 0-based symbol index within the frame (decoded values: 1'b0, 1'b1, 1'bz, 1'bx).
REQ-016 After the last payload symbol (index WORD_SYMS-1, or the parity symbol when enabled), the FSM SHALL enter HOLD with out_valid=1 on the next cycle, i.e. one cycle of latency from acceptance.
REQ-017 In HOLD, out_data and out_err SHALL be stable until out_valid and out_ready are both 1; on that cycle the FSM SHALL go to IDLE.
REQ-018 in_ready SHALL be 1 in IDLE and COLLECT, and in HOLD only when out_ready=1.
REQ-019 If in HOLD with out_ready=1 an accepted symbol has in_sof=1, the FSM SHALL go directly to COLLECT with that symbol as index 0; otherwise the symbol SHALL be discarded.
REQ-020 An accepted symbol with in_sof=1 while in COLLECT SHALL abandon the partial word, restart at index 0 with the new symbol, and increment drop_cnt, saturating at 255.
REQ-021 The symbol index counter SHALL be $clog2(WORD_SYMS+1) bits wide and SHALL reset to 0 on each frame start.

Reset
REQ-022 While rst_n=0: state=IDLE, in_ready=0, out_valid=0, out_data=all 0, out_err=0, drop_cnt=0, index=0.
REQ-023 Reset asserted mid-frame or in HOLD SHALL discard all partial or held data; in_ready SHALL become 1 in the first cycle after rst_n rises.

Configuration
REQ-024 The macro LOGIC4_DESER_PARITY_EN SHALL select frame parity: when defined, each frame SHALL carry one extra symbol after the payload, and out_err SHALL be 1 unless that symbol equals {1'b0, XOR of payload symbols decoded as 1} (z and x count as 0); when undefined, frames SHALL be WORD_SYMS symbols long and out_err SHALL be constant 0.

Verification
REQ-025 Scenario: WORD_SYMS=8, symbols 01,00,10,11,01,01,00,00 with sof on the first and out_ready=1 -> out_valid=1 one cycle after the last symbol, out_data=8'b0011xz01 (bit 0 rightmost).
REQ-026 Scenario: word held with out_ready=0 for 5 cycles -> in_ready=0 and out_data stable throughout; at out_ready=1 the word completes and the block returns to IDLE.
REQ-027 Scenario: sof at symbol index 3 of an in-progress frame -> drop_cnt 0->1, and the next word contains only symbols from the new frame; 300 such restarts -> drop_cnt=255.
REQ-028 Scenario: rst_n pulsed low at index 5 -> out_valid=0, drop_cnt=0; a fresh frame then decodes correctly.
REQ-029 Scenario (macro defined): payload with three symbols equal to 01 and parity symbol 01 -> out_err=0; same payload with parity symbol 00 or 11 -> out_err=1.
REQ-030 Scenario: out_ready=1 in HOLD concurrent with an accepted sof symbol -> the word completes and the new frame starts with no idle cycle.
